// File: rtl/hr_estimator_pkg.sv
// Shared widths and constants for the heart-rate estimator.
// Imported by the top and the divider.
package hr_estimator_pkg;

  localparam int SAMPLE_W = 8;
  localparam int Y_W      = 13;
  localparam int INT_W    = 32;
  localparam int WIN      = 16;
  localparam int DEPTH    = 4;
  localparam int SIXTY    = 60;

  typedef logic signed [Y_W-1:0] y_t;
  typedef logic [INT_W-1:0]      int_t;

endpackage

// File: rtl/hr_bpm_divider.sv
// Registered unsigned 32-bit divider.
// A zero divisor yields a zero quotient.
module hr_bpm_divider
  import hr_estimator_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [INT_W-1:0] i_num,
  input  logic [INT_W-1:0] i_den,
  output logic [INT_W-1:0] o_quo
);

  logic [INT_W-1:0] r_quo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo <= '0;
    end else if (i_den == '0) begin
      r_quo <= '0;
    end else begin
      r_quo <= i_num / i_den;
    end
  end

  assign o_quo = r_quo;

endmodule

// File: rtl/hr_estimator.sv
// ECG moving-sum filter, R-peak detector with refractory window,
// 4-interval average and beats-per-minute output.
module hr_estimator
  import hr_estimator_pkg::*;
#(
  parameter int CLK_FREQ  = 200,
  parameter int THRESHOLD = 600,
  parameter int REFRACT   = CLK_FREQ / 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] Xin,
  output logic signed [Y_W-1:0]      Yout,
  output logic                       peak_detected,
  output logic [INT_W-1:0]           avg_interval,
  output logic [INT_W-1:0]           bpm
);

  localparam y_t   THR     = y_t'(THRESHOLD);
  localparam int_t REF_CNT = int_t'(REFRACT);
  localparam int_t NUM     = int_t'(SIXTY * CLK_FREQ);

  logic signed [SAMPLE_W-1:0] r_dly [WIN-1];
  y_t   w_sum;
  y_t   r_y;
  y_t   r_y1;
  y_t   r_y2;
  logic r_pk;
  logic w_cand;
  logic w_acc;

  int_t       r_cnt;
  int_t       r_fifo [DEPTH];
  logic [2:0] r_nint;
  logic       r_seen;
  logic       r_push;
  int_t       r_avg;
  logic [INT_W+1:0] w_isum;

  always_comb begin
    w_sum = y_t'(Xin);
    for (int i = 0; i < WIN - 1; i++) begin
      w_sum = w_sum + y_t'(r_dly[i]);
    end
  end

  assign w_cand = (r_y1 > THR) && (r_y1 >= r_y2) && (r_y1 > r_y);
  // Before the first peak there is no window to respect.
  assign w_acc  = w_cand && (!r_seen || (r_cnt >= REF_CNT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIN - 1; i++) begin
        r_dly[i] <= '0;
      end
      r_y  <= '0;
      r_y1 <= '0;
      r_y2 <= '0;
      r_pk <= 1'b0;
    end else begin
      r_dly[0] <= Xin;
      for (int i = 1; i < WIN - 1; i++) begin
        r_dly[i] <= r_dly[i-1];
      end
      r_y  <= w_sum;
      r_y1 <= r_y;
      r_y2 <= r_y1;
      r_pk <= w_acc;
    end
  end

  always_comb begin
    w_isum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_isum = w_isum + {2'b00, r_fifo[i]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
      r_nint <= '0;
      r_seen <= 1'b0;
      r_push <= 1'b0;
      r_avg  <= '0;
    end else begin
      r_push <= 1'b0;
      if (w_acc) begin
        r_cnt  <= 32'd1;
        r_seen <= 1'b1;
        if (r_seen) begin
          r_fifo[0] <= r_cnt;
          for (int i = 1; i < DEPTH; i++) begin
            r_fifo[i] <= r_fifo[i-1];
          end
          if (r_nint != 3'(DEPTH)) begin
            r_nint <= r_nint + 3'd1;
          end
          r_push <= 1'b1;
        end
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 32'd1;
      end
      if (r_push && (r_nint == 3'(DEPTH))) begin
        r_avg <= int_t'(w_isum >> 2);
      end
    end
  end

  hr_bpm_divider u_div (
    .clk   (clk),
    .rst_n (rst),
    .i_num (NUM),
    .i_den (r_avg),
    .o_quo (bpm)
  );

  assign Yout          = r_y;
  assign peak_detected = r_pk;
  assign avg_interval  = r_avg;

endmodule

// File: tb/tb_hr_estimator.sv
// Directed bench for hr_estimator: Yout and peak timing are
// scoreboarded every cycle; rate results checked after each beat train.
module tb_hr_estimator;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [7:0]  Xin = '0;
  logic signed [12:0] Yout;
  logic               peak_detected;
  logic [31:0]        avg_interval;
  logic [31:0]        bpm;

  int checks   = 0;
  int failures = 0;
  int k        = 0;

  int                 q_peak [$];
  logic signed [12:0] q_y    [$];
  logic signed [7:0]  hist   [$];

  hr_estimator dut (
    .clk           (clk),
    .rst           (rst),
    .Xin           (Xin),
    .Yout          (Yout),
    .peak_detected (peak_detected),
    .avg_interval  (avg_interval),
    .bpm           (bpm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one sample (called at a negedge) and check at the next negedge.
  task automatic tick(input logic signed [7:0] x);
    logic signed [12:0] e;
    Xin = x;
    e = 13'(x);
    foreach (hist[i]) e = e + 13'(hist[i]);
    q_y.push_back(e);
    hist.push_front(x);
    if (hist.size() > 15) void'(hist.pop_back());
    @(negedge clk);
    chk("yout", 32'(Yout), 32'(q_y.pop_front()));
    if (peak_detected) begin
      if (q_peak.size() == 0) chk("peak_unexpected", k, -1);
      else chk("peak_time", k, q_peak.pop_front());
    end
    k++;
  endtask

  task automatic beat(input int amp, input int period, input bit exp_pk);
    if (exp_pk) q_peak.push_back(k + 17);
    repeat (16) tick(8'(amp));
    repeat (period - 16) tick(8'sd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_yout"}, 32'(Yout), 0);
    chk({tag, "_peak"}, 32'(peak_detected), 0);
    chk({tag, "_avg"},  avg_interval, 0);
    chk({tag, "_bpm"},  bpm, 0);
  endtask

  task automatic do_reset(input string tag);
    chk({tag, "_missed_peaks"}, q_peak.size(), 0);
    q_peak.delete();
    #2 rst = 1'b0;
    Xin = '0;
    #1 chk_zero(tag);
    @(negedge clk);
    rst = 1'b1;
    hist.delete();
  endtask

  task automatic train(input int period, input int n);
    repeat (n) beat(100, period, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    chk_zero("por");
    rst = 1'b1;

    train(150, 4);
    chk("p150_avg_3int", avg_interval, 0);
    chk("p150_bpm_3int", bpm, 0);
    beat(100, 150, 1'b1);
    chk("p150_avg", avg_interval, 150);
    chk("p150_bpm", bpm, 80);

    repeat (8) tick(8'sd100);
    chk("mid_yout_nonzero", 32'(Yout != 0), 1);
    do_reset("mid_rst");

    repeat (16) tick(8'sd10);
    chk("hold_10", 32'(Yout), 160);
    repeat (16) tick(-8'sd128);
    chk("hold_min", 32'(Yout), -2048);
    repeat (16) tick(8'sd127);
    chk("hold_max", 32'(Yout), 2032);
    do_reset("rst_a");

    train(100, 5);
    chk("p100_avg", avg_interval, 100);
    chk("p100_bpm", bpm, 120);
    do_reset("rst_b");

    train(167, 5);
    chk("p167_avg", avg_interval, 167);
    chk("p167_bpm", bpm, 71);
    do_reset("rst_c");

    beat(100, 30, 1'b1);
    beat(100, 120, 1'b0);
    train(150, 3);
    chk("refr_avg_3int", avg_interval, 0);
    beat(100, 150, 1'b1);
    chk("refr_avg", avg_interval, 150);
    chk("refr_bpm", bpm, 80);
    do_reset("rst_d");

    repeat (5) beat(30, 150, 1'b0);
    chk("low_avg", avg_interval, 0);
    chk("low_bpm", bpm, 0);
    chk("final_missed_peaks", q_peak.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hr_estimator.md
HR_ESTIMATOR -- requirements
Module: hr_estimator

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 200: sample/clock rate in Hz; one ECG sample is consumed per clock.
REQ-002 SHALL have parameter THRESHOLD, default 600: signed Yout level a peak must exceed.
REQ-003 SHALL have parameter REFRACT, default CLK_FREQ/4 (50 cycles): minimum cycles between accepted peaks.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port Xin, input, signed 8 bits: ECG sample, sampled every rising edge.
REQ-007 SHALL have port Yout, output, signed 13 bits: filtered ECG.
REQ-008 SHALL have port peak_detected, output, 1 bit: one-cycle pulse per accepted R-peak.
REQ-009 SHALL have port avg_interval, output, 32 bits unsigned: mean of the last 4 peak-to-peak intervals, in cycles.
REQ-010 SHALL have port bpm, output, 32 bits unsigned: heart rate in beats per minute.

Function
REQ-011 SHALL register Yout as the sum of the current Xin and the previous 15 Xin samples, sign-extended; 1 cycle latency; range -2048..2032, no overflow.
REQ-012 SHALL keep registered copies Y1 (Yout of the previous cycle) and Y2 (Yout two cycles back).
REQ-013 SHALL call a candidate when Y1 > THRESHOLD, Y1 >= Y2 and Y1 > Yout (signed compares).
REQ-014 SHALL assert peak_detected for exactly the cycle after a candidate, unless fewer than REFRACT cycles have passed since the last accepted peak.
REQ-015 SHALL count cycles since the last accepted peak in a 32-bit counter that saturates at 0xFFFFFFFF.
REQ-016 SHALL, on each accepted peak after the first, push the counter value (the exact period between pulses) into a 4-entry interval FIFO, then restart the counter at 1.
REQ-017 SHALL NOT record an interval on the first peak after reset; it only restarts the counter.
REQ-018 SHALL hold avg_interval at 0 until 4 intervals are stored, then update it to (sum of the 4 entries) >> 2 on the cycle after each push; the sum is 34 bits wide.
REQ-019 SHALL set bpm to floor((60*CLK_FREQ)/avg_interval) one cycle after avg_interval changes, and to 0 while avg_interval is 0.
REQ-020 SHALL hold bpm and avg_interval unchanged between peaks.
REQ-021 SHALL give a candidate inside the refractory window no effect: no pulse, no counter restart.

Reset
REQ-022 SHALL, while rst is low, clear at once and regardless of clk: Yout, Y1, Y2, the sample delay line, peak_detected, the counter, the FIFO, the interval count, the first-peak flag, avg_interval and bpm.
REQ-023 SHALL treat assertion in mid-operation as a full restart; 4 new intervals are needed before bpm is nonzero again.
REQ-024 SHALL treat the refractory window as elapsed after reset.

Structure
REQ-025 SHALL keep in package hr_estimator_pkg: the sample, Yout and interval widths, the window length (16), the FIFO depth (4) and the constant 60.
REQ-026 SHALL use one sub-module, hr_bpm_divider: a registered unsigned 32-bit divide with a divide-by-zero result of 0.

Verification
REQ-027 SHALL check: rst low mid-stream -> all outputs 0 immediately; after release, Xin=10 held 16 cycles -> Yout=160.
REQ-028 SHALL check: Xin=-128 held 16 cycles -> Yout=-2048; Xin=127 held 16 cycles -> Yout=2032.
REQ-029 SHALL check: 16-sample pulses of amplitude 100 every 150 cycles -> one peak_detected pulse per beat; after the 5th peak, avg_interval=150 and bpm=80.
REQ-030 SHALL check: the same pulses every 100 cycles -> avg_interval=100, bpm=120; every 167 cycles -> bpm=71.
REQ-031 SHALL check: two pulses 30 cycles apart -> only the first asserts peak_detected, and the interval is measured from the first.
REQ-032 SHALL check: pulses of amplitude 30 (Yout peak 480 < THRESHOLD) -> no peak_detected, bpm stays 0.
